// File: rtl/cordic_angle_reducer_if.sv
// Handshake bundle between the angle source, the range reducer and the CORDIC engine.
// The reducer takes the slave view; the source/engine side (or a bench) takes the master view.
interface cordic_angle_reducer_if;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] angle_in;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] angle_out;
  logic        cos_negate;

  modport slave (
    input  in_valid,
    input  angle_in,
    input  out_ready,
    output in_ready,
    output out_valid,
    output angle_out,
    output cos_negate
  );

  modport master (
    output in_valid,
    output angle_in,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  angle_out,
    input  cos_negate
  );
endinterface

// File: rtl/cordic_angle_reducer.sv
// Reduces a signed Q8.16 angle to [-pi/2, pi/2] and flags cosine negation; out_valid 7 edges after accept.
// Result is held until out_ready; in_ready only in IDLE, so the minimum initiation interval is 9 cycles.
module cordic_angle_reducer #(
  parameter logic [23:0] TWO_PI  = 24'h06487F,
  parameter logic [23:0] PI      = 24'h03243F,
  parameter logic [23:0] HALF_PI = 24'h01921F
) (
  input logic                   clk,
  input logic                   reset_n,
  cordic_angle_reducer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REDUCE = 3'd1,
    WRAP   = 3'd2,
    FOLD   = 3'd3,
    HOLD   = 3'd4
  } state_t;

  localparam logic signed [25:0] TWO_PI_W   = signed'({2'b00, TWO_PI});
  localparam logic signed [25:0] PI_W       = signed'({2'b00, PI});
  localparam logic signed [25:0] NEG_PI_W   = -PI_W;
  localparam logic signed [25:0] HALF_PI_W  = signed'({2'b00, HALF_PI});
  localparam logic signed [25:0] NEG_HALF_W = -HALF_PI_W;

  state_t             state_q, state_d;
  logic [24:0]        a_q, a_d;
  logic [2:0]         k_q, k_d;
  logic               s_q, s_d;
  logic signed [25:0] r_q, r_d;
  logic [23:0]        angle_q, angle_d;
  logic               cos_neg_q, cos_neg_d;
  logic               out_valid_q, out_valid_d;

  logic signed [24:0] in_ext;
  logic signed [25:0] a_w;
  logic signed [25:0] step;
  logic signed [25:0] wrapped;

  // Magnitude is 25 bits wide so -128.0 becomes +2^23 without overflow.
  assign in_ext  = signed'({bus.angle_in[23], bus.angle_in});
  assign a_w     = signed'({1'b0, a_q});
  assign step    = TWO_PI_W <<< k_q;
  assign wrapped = (a_w > PI_W) ? (a_w - TWO_PI_W) : a_w;

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    k_d         = k_q;
    s_d         = s_q;
    r_d         = r_q;
    angle_d     = angle_q;
    cos_neg_d   = cos_neg_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          s_d     = bus.angle_in[23];
          a_d     = in_ext[24] ? 25'(-in_ext) : 25'(in_ext);
          k_d     = 3'd4;
          state_d = REDUCE;
        end
      end
      REDUCE: begin
        // Restoring subtraction of 2*pi*2^k; after k=0 the magnitude is below 2*pi.
        if (a_w >= step) begin
          a_d = 25'(a_w - step);
        end
        if (k_q == 3'd0) begin
          state_d = WRAP;
        end else begin
          k_d = k_q - 3'd1;
        end
      end
      WRAP: begin
        r_d     = s_q ? -wrapped : wrapped;
        state_d = FOLD;
      end
      FOLD: begin
        // Reflecting about +-pi/2 keeps sine and flips the cosine sign.
        if (r_q > HALF_PI_W) begin
          angle_d   = 24'(PI_W - r_q);
          cos_neg_d = 1'b1;
        end else if (r_q < NEG_HALF_W) begin
          angle_d   = 24'(NEG_PI_W - r_q);
          cos_neg_d = 1'b1;
        end else begin
          angle_d   = 24'(r_q);
          cos_neg_d = 1'b0;
        end
        out_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      k_q         <= '0;
      s_q         <= 1'b0;
      r_q         <= '0;
      angle_q     <= '0;
      cos_neg_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      k_q         <= k_d;
      s_q         <= s_d;
      r_q         <= r_d;
      angle_q     <= angle_d;
      cos_neg_q   <= cos_neg_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready   = (state_q == IDLE);
  assign bus.out_valid  = out_valid_q;
  assign bus.angle_out  = angle_q;
  assign bus.cos_negate = cos_neg_q;

endmodule
